// File: rtl/vga_timing_pattern_gen.sv
// vga_timing_pattern_gen
//   Single-clock VGA timing generator with built-in test patterns.
//   Line and frame are both ordered active, front porch, sync, back porch.
//   Every output is a registered function of (h_cnt, v_cnt), so all outputs
//   share one clock of latency and stay mutually aligned.
//
//   Optional feature: define SCROLL_EN to scroll patterns 0 and 3 left by one
//   pixel per frame.
//
// Ports
//   clock       in   pixel clock
//   reset_n     in   asynchronous active-low reset
//   sel         in   asynchronous pattern-advance button (level)
//   hs, vs      out  horizontal / vertical sync, polarity set by HS_POL / VS_POL
//   de          out  active-video qualifier
//   r, g, b     out  COLOR_W-bit colour, zero whenever de = 0
//   frame_start out  one-cycle pulse with the first active pixel of a frame
//   pattern     out  displayed pattern index 0..4
//
// Pattern state table
//   pattern | meaning
//   0       | grey ramp, 2**COLOR_W vertical bands
//   1       | solid red
//   2       | solid white
//   3       | eight colour bars
//   4       | checkerboard, 2**CHK_LOG2 pixel squares
module vga_timing_pattern_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int COLOR_W  = 2,
    parameter int CHK_LOG2 = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               sel,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic               frame_start,
    output logic [2:0]         pattern
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int N_BANDS = 2 ** COLOR_W;
    localparam int BAND_W  = H_ACTIVE >> COLOR_W;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [HW-1:0]      H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]      V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0]      H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0]      V_ACT    = VW'(V_ACTIVE);
    localparam logic [HW-1:0]      HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]      HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]      VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]      VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COLOR_W-1:0] C_MAX    = '1;

    logic [HW-1:0]      h_cnt;
    logic [VW-1:0]      v_cnt;
    logic               h_last;
    logic               frame_wrap;
    logic               sel_meta, sel_sync, sel_prev;
    logic               sel_rise;
    logic               pending_adv;
    logic [HW-1:0]      x_scr;
    logic [COLOR_W-1:0] ramp_lvl;
    logic [2:0]         bar_idx;
    logic               de_n;
    logic [COLOR_W-1:0] r_n, g_n, b_n;

    assign h_last     = (h_cnt == H_LAST);
    assign frame_wrap = h_last && (v_cnt == V_LAST);
    assign sel_rise   = sel_sync && !sel_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_meta <= 1'b0;
            sel_sync <= 1'b0;
            sel_prev <= 1'b0;
        end else begin
            sel_meta <= sel;
            sel_sync <= sel_meta;
            sel_prev <= sel_sync;
        end
    end

    // An edge landing on the wrap cycle itself is honoured at that wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pattern     <= 3'd0;
            pending_adv <= 1'b0;
        end else if (frame_wrap) begin
            if (pending_adv || sel_rise) begin
                pattern <= (pattern == 3'd4) ? 3'd0 : pattern + 3'd1;
            end
            pending_adv <= 1'b0;
        end else if (sel_rise) begin
            pending_adv <= 1'b1;
        end
    end

`ifdef SCROLL_EN
    logic [HW-1:0] scroll_off;
    logic [HW:0]   x_sum;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scroll_off <= '0;
        end else if (frame_wrap) begin
            scroll_off <= (scroll_off == HW'(H_ACTIVE - 1)) ? '0 : scroll_off + HW'(1);
        end
    end

    // Both terms are below H_ACTIVE inside the active area, so a single
    // conditional subtract implements the modulo.
    always_comb begin
        x_sum = {1'b0, h_cnt} + {1'b0, scroll_off};
        if (x_sum >= (HW+1)'(H_ACTIVE)) begin
            x_scr = HW'(x_sum - (HW+1)'(H_ACTIVE));
        end else begin
            x_scr = HW'(x_sum);
        end
    end
`else
    always_comb begin
        x_scr = h_cnt;
    end
`endif

    // Band and bar indices by threshold compare; the last band/bar keeps
    // everything past its start, which absorbs any width remainder.
    always_comb begin
        ramp_lvl = '0;
        for (int i = 1; i < N_BANDS; i++) begin
            if (x_scr >= HW'(i * BAND_W)) ramp_lvl = COLOR_W'(i);
        end
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x_scr >= HW'(i * BAR_W)) bar_idx = 3'(i);
        end
    end

    always_comb begin
        de_n = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        r_n  = '0;
        g_n  = '0;
        b_n  = '0;
        case (pattern)
            3'd0: begin
                r_n = ramp_lvl;
                g_n = ramp_lvl;
                b_n = ramp_lvl;
            end
            3'd1: r_n = C_MAX;
            3'd2: begin
                r_n = C_MAX;
                g_n = C_MAX;
                b_n = C_MAX;
            end
            3'd3: begin
                // Bar order white..black maps to inverted index bits.
                r_n = bar_idx[1] ? '0 : C_MAX;
                g_n = bar_idx[2] ? '0 : C_MAX;
                b_n = bar_idx[0] ? '0 : C_MAX;
            end
            3'd4: begin
                if (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) begin
                    r_n = C_MAX;
                    g_n = C_MAX;
                    b_n = C_MAX;
                end
            end
            default: ;
        endcase
        if (!de_n) begin
            r_n = '0;
            g_n = '0;
            b_n = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hs          <= !HS_POL;
            vs          <= !VS_POL;
            de          <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            frame_start <= 1'b0;
        end else begin
            hs          <= (h_cnt >= HS_START && h_cnt < HS_END) ? HS_POL : !HS_POL;
            vs          <= (v_cnt >= VS_START && v_cnt < VS_END) ? VS_POL : !VS_POL;
            de          <= de_n;
            r           <= r_n;
            g           <= g_n;
            b           <= b_n;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// tb_vga_timing_pattern_gen
//   Directed bench on a shrunken raster: 18 active + 2 FP + 3 sync + 3 BP
//   pixels (26 per line), 6 active + 1 FP + 2 sync + 1 BP lines (10 per frame),
//   260 clocks per frame. hsync active-high, vsync active-low.
//   cyc counts rising edges since reset release; the output seen after edge
//   cyc belongs to raster pixel cyc-1.
module tb_vga_timing_pattern_gen;

    localparam int HA = 18, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 6, VFP = 1, VSY = 2, VBP = 1;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FR = HT * VT;
    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          sel;
    logic          hs, vs, de, frame_start;
    logic [CW-1:0] r, g, b;
    logic [2:0]    pattern;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    vga_timing_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b0), .COLOR_W(CW), .CHK_LOG2(1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .sel(sel),
        .hs(hs), .vs(vs), .de(de), .r(r), .g(g), .b(b),
        .frame_start(frame_start), .pattern(pattern)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic press(input int at);
        run_to(at);
        sel = 1'b1;
        repeat (3) tick();
        sel = 1'b0;
        repeat (3) tick();
    endtask

    function automatic int cyc_of(input int frame, input int line, input int x);
        return frame * FR + line * HT + x + 1;
    endfunction

    function automatic int scr(input int x, input int frame);
`ifdef SCROLL_EN
        return (x + frame % HA) % HA;
`else
        return x + 0 * frame;
`endif
    endfunction

    // {r,g,b} packed, 2 bits each: white 63, yellow 60, cyan 15, green 12,
    // magenta 51, red 48, blue 3, black 0; bars are 2 px, 16..17 black.
    function automatic logic [5:0] bar_col(input int xp);
        int idx;
        idx = (xp < 16) ? xp / 2 : 7;
        case (idx)
            0: return 6'd63;
            1: return 6'd60;
            2: return 6'd15;
            3: return 6'd12;
            4: return 6'd51;
            5: return 6'd48;
            6: return 6'd3;
            default: return 6'd0;
        endcase
    endfunction

    initial begin
        int p, hs_first, hs_cnt, hs_line0, de_cnt, vs_first, vs_cnt;
        int fs_cnt, fs_last, blank_bad;
        logic [5:0] line0 [HT];

        reset_n = 1'b0;
        sel     = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_hs", hs, 0);
        check("rst_vs", vs, 1);
        check("rst_de", de, 0);
        check("rst_rgb", {r, g, b}, 0);
        check("rst_fs", frame_start, 0);
        check("rst_pat", pattern, 0);

        reset_n = 1'b1;
        cyc = 0;
        hs_first = -1; hs_cnt = 0; hs_line0 = 0; de_cnt = 0;
        vs_first = -1; vs_cnt = 0; fs_cnt = 0; fs_last = -1; blank_bad = 0;
        for (int k = 0; k < 2 * FR; k++) begin
            tick();
            p = cyc - 1;
            if (hs) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = p;
                if (p < HT) hs_line0++;
            end
            if (!vs) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = p;
            end
            if (de) de_cnt++;
            if (frame_start) begin
                fs_cnt++;
                fs_last = p;
            end
            if (!de && ({r, g, b} != 6'd0)) blank_bad++;
            if (p < HT) line0[p] = {r, g, b};
        end
        check("hs_first", hs_first, 20);
        check("hs_line0", hs_line0, 3);
        check("hs_total", hs_cnt, 60);
        check("de_total", de_cnt, 216);
        check("vs_first", vs_first, 182);
        check("vs_total", vs_cnt, 104);
        check("fs_count", fs_cnt, 2);
        check("fs_last", fs_last, 260);
        check("blank_rgb", blank_bad, 0);
        check("ramp_x0", line0[0], 0);
        check("ramp_x3", line0[3], 0);
        check("ramp_x4", line0[4], 21);
        check("ramp_x8", line0[8], 42);
        check("ramp_x12", line0[12], 63);
        check("ramp_x17", line0[17], 63);
        check("ramp_x18", line0[18], 0);

        // three presses in frame 2 advance the pattern once, at the wrap
        press(2 * FR + 40);
        press(2 * FR + 50);
        press(2 * FR + 60);
        run_to(3 * FR - 1);
        check("pat_hold", pattern, 0);
        tick();
        check("pat_adv1", pattern, 1);
        run_to(cyc_of(3, 2, 5));
        check("red_rgb", {r, g, b}, 48);

        press(3 * FR + 70);
        run_to(4 * FR - 1);
        check("pat_hold2", pattern, 1);
        tick();
        check("pat_adv2", pattern, 2);
        tick();
        check("white_rgb", {r, g, b}, 63);
        check("white_fs", frame_start, 1);

        press(4 * FR + 80);
        run_to(5 * FR);
        check("pat_adv3", pattern, 3);
        for (int x = 0; x < HA; x++) begin
            run_to(cyc_of(5, 1, x));
            check($sformatf("bar_x%0d", x), {r, g, b}, bar_col(scr(x, 5)));
        end

        press(5 * FR + 100);
        run_to(6 * FR);
        check("pat_adv4", pattern, 4);
        run_to(cyc_of(6, 0, 0)); check("chk_0_0", {r, g, b}, 0);
        run_to(cyc_of(6, 0, 2)); check("chk_2_0", {r, g, b}, 63);
        run_to(cyc_of(6, 0, 4)); check("chk_4_0", {r, g, b}, 0);
        run_to(cyc_of(6, 2, 0)); check("chk_0_2", {r, g, b}, 63);
        run_to(cyc_of(6, 2, 2)); check("chk_2_2", {r, g, b}, 0);

        press(6 * FR + 110);
        run_to(7 * FR);
        check("pat_wrap0", pattern, 0);

        // synchronised edge arrives exactly on the frame wrap
        run_to(8 * FR - 3);
        sel = 1'b1;
        run_to(8 * FR - 1);
        check("coinc_before", pattern, 0);
        tick();
        check("coinc_adv", pattern, 1);
        run_to(8 * FR + 5);
        sel = 1'b0;
        run_to(9 * FR);
        check("pend_cleared", pattern, 1);

        // asynchronous reset in the middle of an active red line
        run_to(cyc_of(9, 1, 5));
        check("pre_rst_rgb", {r, g, b}, 48);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_de", de, 0);
        check("mid_rst_hs", hs, 0);
        check("mid_rst_vs", vs, 1);
        check("mid_rst_rgb", {r, g, b}, 0);
        check("mid_rst_pat", pattern, 0);
        @(negedge clock);
        reset_n = 1'b1;
        cyc = 0;
        tick();
        check("post_rst_fs", frame_start, 1);
        check("post_rst_de", de, 1);
        check("post_rst_rgb0", {r, g, b}, 0);
        run_to(5);
        check("post_rst_rgb4", {r, g, b}, 21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
